// File: rtl/rx_dump.sv
// Read-side sequencer for the Rejestry register file: walks a range of Rx registers
// through the file's read port and streams each value out on a valid/ready interface.
module rx_dump #(
    parameter  int Rx_liczba    = 8,
    parameter  int Rx_rozm_data = 8,
    localparam int IW           = (Rx_liczba > 1) ? $clog2(Rx_liczba) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [IW-1:0]           first_nr,
    input  logic [IW:0]             count,
    output logic                    bus_req,
    output logic [IW-1:0]           rd_nr,
    input  logic [Rx_rozm_data-1:0] rd_dane,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [Rx_rozm_data-1:0] out_data,
    output logic [IW-1:0]           out_nr,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        DONE
    } state_t;

    localparam logic [IW:0]   NUM_REGS = (IW+1)'(Rx_liczba);
    localparam logic [IW-1:0] LAST_NR  = IW'(Rx_liczba - 1);
    localparam logic [IW:0]   ONE_REM  = (IW+1)'(1);

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] idx;
    logic [IW:0]   remaining;
    logic [IW-1:0] start_idx;
    logic [IW:0]   start_rem;
    logic          last_word;

    // Out-of-range start index restarts at register 0; count 0 or too large means a full sweep.
    assign start_idx = ({1'b0, first_nr} >= NUM_REGS) ? '0 : first_nr;
    assign start_rem = ((count == '0) || (count > NUM_REGS)) ? NUM_REGS : count;
    assign last_word = (remaining == ONE_REM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bus_req   = 1'b0;
        rd_nr     = '0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = READ;
            end
            READ: begin
                bus_req   = 1'b1;
                rd_nr     = idx;
                state_nxt = SEND;
            end
            SEND: begin
                bus_req   = 1'b1;
                rd_nr     = idx;
                out_valid = 1'b1;
                if (out_ready) state_nxt = last_word ? DONE : READ;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Abort overrides everything, including a same-cycle start or handshake.
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx       <= '0;
            remaining <= '0;
            out_data  <= '0;
            out_nr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        idx       <= start_idx;
                        remaining <= start_rem;
                    end
                end
                READ: begin
                    out_data <= rd_dane;
                    out_nr   <= idx;
                end
                SEND: begin
                    if (out_ready && !last_word) begin
                        remaining <= remaining - ONE_REM;
                        idx       <= (idx == LAST_NR) ? '0 : idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_dump.sv
// Bench for rx_dump: a register-file model feeds the read port and each dump is
// predicted as a queue of register indices derived from first/count with modular arithmetic.
module tb_rx_dump;

    localparam int N  = 8;
    localparam int DW = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;
    logic [IW-1:0] first_nr = '0;
    logic [IW:0]   count = '0;
    logic          bus_req;
    logic [IW-1:0] rd_nr;
    logic [DW-1:0] rd_dane;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_nr;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [N];

    int checks = 0;
    int errors = 0;

    rx_dump #(.Rx_liczba(N), .Rx_rozm_data(DW)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .first_nr(first_nr),
        .count(count),
        .bus_req(bus_req),
        .rd_nr(rd_nr),
        .rd_dane(rd_dane),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_nr(out_nr),
        .busy(busy),
        .done(done)
    );

    assign rd_dane = mem[rd_nr];

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One dump: stall_word holds ready low 5 cycles, poke_word re-pulses start,
    // abort_word aborts during that word's SEND (negative disables each).
    task automatic apply_stimulus(input int first, input int cnt, input int ready_pct,
                                  input int stall_word, input int poke_word, input int abort_word);
        int  q[$];
        int  f, n, word, stall, guard, pend;
        bit  rdy, aborted;
        f = (first >= N) ? 0 : first;
        n = (cnt == 0) ? N : ((cnt > N) ? N : cnt);
        for (int i = 0; i < n; i++) q.push_back((f + i) % N);
        @(negedge clk);
        first_nr  = IW'(first);
        count     = (IW+1)'(cnt);
        start     = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        start    = 1'b0;
        first_nr = IW'($urandom);
        count    = (IW+1)'($urandom);
        check_output("start_busy", 32'(busy), 32'd1);
        check_output("start_bus_req", 32'(bus_req), 32'd1);
        check_output("start_valid", 32'(out_valid), 32'd0);
        check_output("start_rd_nr", 32'(rd_nr), 32'(q[0]));
        pend = 1; word = 0; stall = 0; guard = 0; aborted = 1'b0;
        while (q.size() > 0) begin
            @(negedge clk);
            start = 1'b0;
            guard++;
            if (guard > 1000) begin
                checks++;
                errors++;
                $error("[TB] FAIL timeout observed %0d words expected %0d", word, n);
                break;
            end
            if (pend > 0) pend--;
            if (pend == 0) begin
                check_output("send_valid", 32'(out_valid), 32'd1);
                check_output("send_nr", 32'(out_nr), 32'(q[0]));
                check_output("send_data", 32'(out_data), 32'(mem[q[0]]));
                check_output("send_bus_req", 32'(bus_req), 32'd1);
                check_output("send_done", 32'(done), 32'd0);
                if (word == poke_word) begin
                    start    = 1'b1;
                    first_nr = IW'(3);
                    count    = (IW+1)'(2);
                end
                rdy = ($urandom_range(99) < ready_pct);
                if (word == stall_word && stall < 5) begin
                    rdy = 1'b0;
                    stall++;
                end
                out_ready = rdy;
                if (word == abort_word) begin
                    abort     = 1'b1;
                    out_ready = 1'b1;
                    aborted   = 1'b1;
                    break;
                end
                if (rdy) begin
                    void'(q.pop_front());
                    word++;
                    pend = 2;
                end
            end else begin
                check_output("read_valid", 32'(out_valid), 32'd0);
                check_output("read_rd_nr", 32'(rd_nr), 32'(q[0]));
                check_output("read_bus_req", 32'(bus_req), 32'd1);
                check_output("read_done", 32'(done), 32'd0);
                out_ready = 1'($urandom_range(1));
            end
        end
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b0;
        if (aborted) begin
            abort = 1'b0;
            check_output("abort_busy", 32'(busy), 32'd0);
            check_output("abort_valid", 32'(out_valid), 32'd0);
            check_output("abort_bus_req", 32'(bus_req), 32'd0);
            check_output("abort_done", 32'(done), 32'd0);
            repeat (3) begin
                @(negedge clk);
                check_output("abort_no_done", 32'(done), 32'd0);
                check_output("abort_idle", 32'(busy), 32'd0);
            end
        end else begin
            check_output("done_pulse", 32'(done), 32'd1);
            check_output("done_valid", 32'(out_valid), 32'd0);
            check_output("done_bus_req", 32'(bus_req), 32'd0);
            check_output("done_busy", 32'(busy), 32'd1);
            check_output("done_rd_nr", 32'(rd_nr), 32'd0);
            @(negedge clk);
            check_output("done_once", 32'(done), 32'd0);
            check_output("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) mem[i] = DW'(8'h10 + i);
        #2;
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_valid", 32'(out_valid), 32'd0);
        check_output("rst_bus_req", 32'(bus_req), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_data", 32'(out_data), 32'd0);
        check_output("rst_nr", 32'(out_nr), 32'd0);
        check_output("rst_rd_nr", 32'(rd_nr), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        $display("[TB] full sweep and wrapped range");
        apply_stimulus(0, 0, 100, -1, -1, -1);
        apply_stimulus(6, 4, 100, -1, -1, -1);

        $display("[TB] backpressure, start while busy, abort");
        apply_stimulus(2, 5, 100, 2, -1, -1);
        apply_stimulus(0, 4, 100, -1, 1, -1);
        apply_stimulus(0, 0, 100, -1, -1, 1);

        $display("[TB] asynchronous reset mid-dump");
        @(negedge clk);
        first_nr = IW'(1);
        count    = '0;
        start    = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check_output("arst_busy", 32'(busy), 32'd0);
        check_output("arst_valid", 32'(out_valid), 32'd0);
        check_output("arst_bus_req", 32'(bus_req), 32'd0);
        check_output("arst_done", 32'(done), 32'd0);
        check_output("arst_data", 32'(out_data), 32'd0);
        check_output("arst_nr", 32'(out_nr), 32'd0);
        check_output("arst_rd_nr", 32'(rd_nr), 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
        rst       = 1'b1;
        apply_stimulus(5, 3, 100, -1, -1, -1);

        $display("[TB] randomized dumps");
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
            apply_stimulus(int'($urandom_range(N - 1)), int'($urandom_range(15)),
                           int'($urandom_range(100, 30)), -1, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
